// File: rtl/wb_bus_ic_if.sv
// ----------------------------------------------------------------------------
// wb_bus_ic_if
// Signal bundle for the single-master Wishbone interconnect wb_bus_ic.
//
// Parameters : NSLAVES, ADR_W, DAT_W, SEL_W (must match the interconnect).
// Modports   :
//   slave  - the interconnect's own port. It is the slave of the bus master
//            and it drives the slave channel strobes.
//   master - the environment side. It drives master requests and the slave
//            responses, and it observes the interconnect outputs.
// Signals (names are from the interconnect's point of view):
//   m_stb_i/m_we_i/m_adr_i/m_dat_i   master request
//   m_dat_o/m_ack_o/m_err_o/busy_o   master response and status
//   s_stb_o/s_we_o/s_adr_o/s_dat_o   slave request (strobe is one-hot)
//   s_dat_i/s_ack_i                  slave responses (slave k: [k*DAT_W +: DAT_W])
//   err_cnt_o/last_err_adr_o         error statistics
// ----------------------------------------------------------------------------
interface wb_bus_ic_if #(
    parameter int NSLAVES = 12,
    parameter int ADR_W   = 8,
    parameter int DAT_W   = 8,
    parameter int SEL_W   = 4
);
    logic                     m_stb_i;
    logic                     m_we_i;
    logic [ADR_W-1:0]         m_adr_i;
    logic [DAT_W-1:0]         m_dat_i;
    logic [DAT_W-1:0]         m_dat_o;
    logic                     m_ack_o;
    logic                     m_err_o;
    logic                     busy_o;
    logic [NSLAVES-1:0]       s_stb_o;
    logic                     s_we_o;
    logic [ADR_W-SEL_W-1:0]   s_adr_o;
    logic [DAT_W-1:0]         s_dat_o;
    logic [NSLAVES*DAT_W-1:0] s_dat_i;
    logic [NSLAVES-1:0]       s_ack_i;
    logic [7:0]               err_cnt_o;
    logic [ADR_W-1:0]         last_err_adr_o;

    modport slave (
        input  m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, busy_o,
        output s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output err_cnt_o, last_err_adr_o
    );

    modport master (
        output m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, busy_o,
        input  s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  err_cnt_o, last_err_adr_o
    );
endinterface

// File: rtl/wb_bus_ic.sv
// ----------------------------------------------------------------------------
// wb_bus_ic
// Parametrised single-master Wishbone interconnect. The upper SEL_W address
// bits select one of NSLAVES slave channels. The request is registered and
// the selected slave is strobed until it acks. The master then sees a
// one-cycle ack pulse carrying the slave's data.
// Unmapped addresses produce a one-cycle error pulse. When the optional
// timeout is built in, a slave that stays silent for TIMEOUT_CYC strobe
// cycles also produces one.
//
// Optional feature macro: WB_IC_TIMEOUT_EN
//   defined   - no-ack timeout counter and timeout error path are present
//   undefined - ACTIVE waits indefinitely for the slave ack; TIMEOUT_CYC unused
//
// Ports:
//   clk_i  - system clock, all logic on the rising edge
//   rst_i  - synchronous active-low reset
//   bus    - wb_bus_ic_if.slave bundle (master request/response, one-hot
//            slave strobes, slave data/acks, error count, last error address)
// ----------------------------------------------------------------------------
module wb_bus_ic #(
    parameter int NSLAVES     = 12,
    parameter int ADR_W       = 8,
    parameter int DAT_W       = 8,
    parameter int SEL_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_bus_ic_if.slave  bus
);
    localparam int SADR_W = ADR_W - SEL_W;

    if (NSLAVES < 1 || NSLAVES > 16 || NSLAVES > (1 << SEL_W) || SADR_W < 1 ||
        TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("wb_bus_ic: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [SEL_W-1:0]   r_idx;
    logic               r_we;
    logic [ADR_W-1:0]   r_adr;
    logic [DAT_W-1:0]   r_wdat;
    logic [DAT_W-1:0]   r_rdat;
    logic [7:0]         r_err_cnt;
    logic [ADR_W-1:0]   r_last_err_adr;

    logic [SEL_W-1:0]   w_req_idx;
    logic               w_req_mapped;
    logic               w_accept;
    logic               w_sel_ack;
    logic [DAT_W-1:0]   w_sel_dat;
    logic               w_timeout;
    logic [NSLAVES-1:0] w_stb;
    logic               w_ack;
    logic               w_err;
    logic               w_busy;

    assign w_req_idx    = bus.m_adr_i[ADR_W-1 -: SEL_W];
    // One extra bit so NSLAVES == 2^SEL_W compares correctly.
    assign w_req_mapped = ({1'b0, w_req_idx} < (SEL_W + 1)'(NSLAVES));

    // Only the latched slave's ack and data are ever looked at; acks from
    // other channels fall out of this mux.
    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (r_idx == SEL_W'(k)) begin
                w_sel_ack = bus.s_ack_i[k];
                w_sel_dat = bus.s_dat_i[k*DAT_W +: DAT_W];
            end
        end
    end

`ifdef WB_IC_TIMEOUT_EN
    logic [7:0] r_tcnt;

    // Held at zero outside ACTIVE, so it always starts from zero on entry.
    // It counts strobe cycles without ack. On the TIMEOUT_CYC-th silent
    // cycle it flags the timeout, unless an ack arrives in that same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_tcnt <= '0;
        end else if (r_state != ST_ACTIVE) begin
            r_tcnt <= '0;
        end else if (!w_sel_ack) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

    assign w_timeout = (r_tcnt == 8'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.m_stb_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_req_mapped ? ST_ACTIVE : ST_ERR;
                end
            end
            ST_ACTIVE: begin
                // Ack wins over a timeout flagged in the same cycle.
                if (w_sel_ack) begin
                    w_state_nxt = ST_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_RESP: begin
                w_ack       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    for (genvar k = 0; k < NSLAVES; k++) begin : g_stb
        assign w_stb[k] = (r_state == ST_ACTIVE) && (r_idx == SEL_W'(k));
    end

    // Request latch, read-data capture and error statistics
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_idx          <= '0;
            r_we           <= 1'b0;
            r_adr          <= '0;
            r_wdat         <= '0;
            r_rdat         <= '0;
            r_err_cnt      <= '0;
            r_last_err_adr <= '0;
        end else begin
            if (w_accept) begin
                r_idx  <= w_req_idx;
                r_we   <= bus.m_we_i;
                r_adr  <= bus.m_adr_i;
                r_wdat <= bus.m_dat_i;
            end
            // Captured on writes too: the master sees whatever the slave returned.
            if (r_state == ST_ACTIVE && w_sel_ack) begin
                r_rdat <= w_sel_dat;
            end
            // The count and address update at the edge ending the error pulse.
            if (r_state == ST_ERR) begin
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
                r_last_err_adr <= r_adr;
            end
        end
    end

    assign bus.s_stb_o        = w_stb;
    assign bus.s_we_o         = r_we;
    assign bus.s_adr_o        = r_adr[SADR_W-1:0];
    assign bus.s_dat_o        = r_wdat;
    assign bus.m_dat_o        = r_rdat;
    assign bus.m_ack_o        = w_ack;
    assign bus.m_err_o        = w_err;
    assign bus.busy_o         = w_busy;
    assign bus.err_cnt_o      = r_err_cnt;
    assign bus.last_err_adr_o = r_last_err_adr;

endmodule

// File: tb/tb_wb_bus_ic.sv
// ----------------------------------------------------------------------------
// tb_wb_bus_ic
// Self-checking bench for wb_bus_ic. A transaction-level reference model
// tracks the outstanding request, the strobe age and the pending pulses. A
// compare process checks every DUT output against the model on each falling
// edge. Directed scenarios pin literal values, then randomized traffic runs.
// Build with +define+WB_IC_TIMEOUT_EN to enable the timeout scenarios.
// ----------------------------------------------------------------------------
module tb_wb_bus_ic;
    localparam int NSLAVES     = 12;
    localparam int ADR_W       = 8;
    localparam int DAT_W       = 8;
    localparam int SEL_W       = 4;
    localparam int TIMEOUT_CYC = 4;
`ifdef WB_IC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    wb_bus_ic_if #(.NSLAVES(NSLAVES), .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) bus ();

    wb_bus_ic #(
        .NSLAVES(NSLAVES), .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (transaction level) ----------------
    bit               mdl_act;     // a mapped request is being strobed
    int               mdl_cyc;     // strobe cycles elapsed without ack
    logic [SEL_W-1:0] mdl_idx;
    logic             mdl_we;
    logic [ADR_W-1:0] mdl_adr;
    logic [DAT_W-1:0] mdl_wdat;
    logic [DAT_W-1:0] mdl_rdat;
    bit               mdl_ack;     // ack pulse expected in the current cycle
    bit               mdl_err;     // error pulse expected in the current cycle
    int               mdl_errcnt;
    logic [ADR_W-1:0] mdl_lerr;

    always @(posedge clk) begin
        bit pulse;
        if (!rst_i) begin
            mdl_act = 0; mdl_cyc = 0; mdl_idx = '0; mdl_we = 1'b0; mdl_adr = '0;
            mdl_wdat = '0; mdl_rdat = '0; mdl_ack = 0; mdl_err = 0;
            mdl_errcnt = 0; mdl_lerr = '0;
        end else begin
            if (mdl_err) begin
                mdl_errcnt = (mdl_errcnt < 255) ? mdl_errcnt + 1 : 255;
                mdl_lerr   = mdl_adr;
            end
            pulse   = mdl_ack || mdl_err;
            mdl_ack = 0;
            mdl_err = 0;
            if (mdl_act) begin
                if (bus.s_ack_i[mdl_idx]) begin
                    mdl_rdat = bus.s_dat_i[int'(mdl_idx)*DAT_W +: DAT_W];
                    mdl_ack  = 1;
                    mdl_act  = 0;
                end else begin
                    mdl_cyc++;
                    if (TO_EN && mdl_cyc == TIMEOUT_CYC) begin
                        mdl_err = 1;
                        mdl_act = 0;
                    end
                end
            end else if (!pulse && bus.m_stb_i) begin
                mdl_we   = bus.m_we_i;
                mdl_adr  = bus.m_adr_i;
                mdl_wdat = bus.m_dat_i;
                mdl_idx  = bus.m_adr_i[ADR_W-1 -: SEL_W];
                if (int'(mdl_idx) < NSLAVES) begin
                    mdl_act = 1;
                    mdl_cyc = 0;
                end else begin
                    mdl_err = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("s_stb",   32'(bus.s_stb_o), mdl_act ? (32'd1 << mdl_idx) : 32'd0);
            chk("s_we",    32'(bus.s_we_o), 32'(mdl_we));
            chk("s_adr",   32'(bus.s_adr_o), 32'(mdl_adr[ADR_W-SEL_W-1:0]));
            chk("s_dat",   32'(bus.s_dat_o), 32'(mdl_wdat));
            chk("m_ack",   32'(bus.m_ack_o), 32'(mdl_ack));
            chk("m_err",   32'(bus.m_err_o), 32'(mdl_err));
            chk("busy",    32'(bus.busy_o), 32'(mdl_act || mdl_ack || mdl_err));
            chk("m_dat",   32'(bus.m_dat_o), 32'(mdl_rdat));
            chk("err_cnt", 32'(bus.err_cnt_o), 32'(mdl_errcnt));
            chk("lerr",    32'(bus.last_err_adr_o), 32'(mdl_lerr));
        end
    end

    // ---------------- slave responder and drivers ----------------
    bit               noise_en   = 0;  // random acks on non-selected slaves
    bit               rand_ack   = 0;  // selected slave acks with probability 1/4
    int               ack_delay  = 0;  // ack in strobe cycle ack_delay (-1: never)
    bit               fix_dat_en = 0;
    logic [DAT_W-1:0] fix_dat    = '0;

    task automatic respond();
        logic [NSLAVES-1:0]       a;
        logic [NSLAVES*DAT_W-1:0] d;
        for (int k = 0; k < NSLAVES; k++) d[k*DAT_W +: DAT_W] = DAT_W'($urandom);
        a = '0;
        if (noise_en) a = NSLAVES'($urandom);
        if (mdl_act) begin
            a[mdl_idx] = 1'b0;
            if (rand_ack) a[mdl_idx] = ($urandom_range(0, 3) == 0);
            else if (ack_delay >= 0 && mdl_cyc == ack_delay) a[mdl_idx] = 1'b1;
            if (fix_dat_en) d[int'(mdl_idx)*DAT_W +: DAT_W] = fix_dat;
        end
        bus.s_ack_i = a;
        bus.s_dat_i = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        respond();
    endtask

    task automatic req(input logic we, input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] dat);
        bus.m_stb_i = 1'b1;
        bus.m_we_i  = we;
        bus.m_adr_i = adr;
        bus.m_dat_i = dat;
        tick();
        bus.m_stb_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((mdl_act || mdl_ack || mdl_err) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_wait actual=busy required=idle within 50 cycles", name);
        end
    endtask

    initial begin
        int n_ack;
        int n_err;
        int n_stb;
        bus.m_stb_i = 1'b0; bus.m_we_i = 1'b0; bus.m_adr_i = '0; bus.m_dat_i = '0;
        bus.s_ack_i = '0;   bus.s_dat_i = '0;

        tick();
        tick();
        chk_on = 1;
        chk("rst_busy",  32'(bus.busy_o), 32'd0);
        chk("rst_stb",   32'(bus.s_stb_o), 32'd0);
        chk("rst_cnt",   32'(bus.err_cnt_o), 32'd0);
        chk("rst_mdat",  32'(bus.m_dat_o), 32'd0);
        rst_i = 1'b1;
        tick();

        // Unmapped address: error in the cycle after the request, no strobe.
        req(1'b0, 8'hF0, 8'h00);
        chk("unm_err",  32'(bus.m_err_o), 32'd1);
        chk("unm_stb",  32'(bus.s_stb_o), 32'd0);
        tick();
        chk("unm_cnt",  32'(bus.err_cnt_o), 32'd1);
        chk("unm_lerr", 32'(bus.last_err_adr_o), 32'hF0);
        chk("unm_idle", 32'(bus.busy_o), 32'd0);

        // Read from slave 3; it acks in the third strobe cycle with A5.
        ack_delay = 2; fix_dat_en = 1; fix_dat = 8'hA5;
        req(1'b0, 8'h35, 8'h00);
        chk("rd_stb",   32'(bus.s_stb_o), 32'h008);
        chk("rd_adr",   32'(bus.s_adr_o), 32'h5);
        chk("rd_we",    32'(bus.s_we_o), 32'd0);
        tick(); tick();
        chk("rd_early", 32'(bus.m_ack_o), 32'd0);
        tick();
        chk("rd_ack",   32'(bus.m_ack_o), 32'd1);
        chk("rd_dat",   32'(bus.m_dat_o), 32'hA5);
        chk("rd_mdl",   32'(mdl_rdat), 32'hA5);
        tick();
        chk("rd_pulse", 32'(bus.m_ack_o), 32'd0);
        chk("rd_hold",  32'(bus.m_dat_o), 32'hA5);

        // Write to slave 11; it acks in the first strobe cycle returning 77.
        ack_delay = 0; fix_dat = 8'h77;
        req(1'b1, 8'hB2, 8'h3C);
        chk("wr_stb",   32'(bus.s_stb_o), 32'h800);
        chk("wr_we",    32'(bus.s_we_o), 32'd1);
        chk("wr_dat",   32'(bus.s_dat_o), 32'h3C);
        chk("wr_adr",   32'(bus.s_adr_o), 32'h2);
        tick();
        chk("wr_ack",   32'(bus.m_ack_o), 32'd1);
        chk("wr_ret",   32'(bus.m_dat_o), 32'h77);
        tick();

        // Busy drop and foreign acks; slave 1 acks in the 4th (last allowed) cycle.
        noise_en = 1; ack_delay = 3; fix_dat = 8'h5A;
        req(1'b0, 8'h12, 8'h00);
        bus.m_stb_i = 1'b1; bus.m_adr_i = 8'h40; bus.m_we_i = 1'b1;
        n_ack = 0; n_err = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) bus.m_stb_i = 1'b0;
            if (bus.m_ack_o === 1'b1) n_ack++;
            if (bus.m_err_o === 1'b1) n_err++;
            tick();
        end
        chk("bd_acks",  32'(n_ack), 32'd1);
        chk("bd_errs",  32'(n_err), 32'd0);
        chk("bd_dat",   32'(bus.m_dat_o), 32'h5A);
        noise_en = 0;

`ifdef WB_IC_TIMEOUT_EN
        // Silent slave: exactly TIMEOUT_CYC strobe cycles, then one error.
        ack_delay = -1;
        req(1'b0, 8'h21, 8'h00);
        n_stb = 0; n_err = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.s_stb_o !== '0) n_stb++;
            if (bus.m_err_o === 1'b1) n_err++;
            tick();
        end
        chk("to_stb",   32'(n_stb), 32'd4);
        chk("to_err",   32'(n_err), 32'd1);
        chk("to_cnt",   32'(bus.err_cnt_o), 32'd2);
        chk("to_lerr",  32'(bus.last_err_adr_o), 32'h21);
        // Ack in the final allowed cycle beats the timeout.
        ack_delay = 3;
        req(1'b0, 8'h21, 8'h00);
        n_ack = 0; n_err = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.m_ack_o === 1'b1) n_ack++;
            if (bus.m_err_o === 1'b1) n_err++;
            tick();
        end
        chk("tl_ack",   32'(n_ack), 32'd1);
        chk("tl_err",   32'(n_err), 32'd0);
        chk("tl_cnt",   32'(bus.err_cnt_o), 32'd2);
`endif

        // Reset in the middle of a strobe: everything clears, no response.
        ack_delay = -1;
        req(1'b0, 8'h21, 8'h00);
        tick(); tick();
`ifndef WB_IC_TIMEOUT_EN
        repeat (18) tick();
        chk("nt_busy",  32'(bus.busy_o), 32'd1);
        chk("nt_stb",   32'(bus.s_stb_o), 32'h004);
        chk("nt_cnt",   32'(bus.err_cnt_o), 32'd1);
`endif
        rst_i = 1'b0;
        tick();
        chk("mr_busy",  32'(bus.busy_o), 32'd0);
        chk("mr_stb",   32'(bus.s_stb_o), 32'd0);
        chk("mr_ack",   32'(bus.m_ack_o), 32'd0);
        chk("mr_cnt",   32'(bus.err_cnt_o), 32'd0);
        chk("mr_sadr",  32'(bus.s_adr_o), 32'd0);
        rst_i = 1'b1;
        ack_delay = 1; fix_dat = 8'hC3;
        req(1'b0, 8'h47, 8'h00);
        chk("pr_stb",   32'(bus.s_stb_o), 32'h010);
        tick(); tick();
        chk("pr_ack",   32'(bus.m_ack_o), 32'd1);
        chk("pr_dat",   32'(bus.m_dat_o), 32'hC3);
        tick();

        // Randomized traffic with foreign acks, busy drops and rare resets.
        fix_dat_en = 0; rand_ack = 1; noise_en = 1;
        for (int i = 0; i < 2500; i++) begin
            rst_i = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            bus.m_stb_i = (!(mdl_ack || mdl_err) && $urandom_range(0, 2) == 0);
            bus.m_we_i  = 1'($urandom);
            bus.m_adr_i = ADR_W'($urandom);
            bus.m_dat_i = DAT_W'($urandom);
            tick();
        end
        rst_i = 1'b1; bus.m_stb_i = 1'b0; rand_ack = 0; noise_en = 0; ack_delay = 0;
        wait_idle("rand");

        // Error counter saturation.
        for (int i = 0; i < 259; i++) begin
            req(1'b0, 8'hD0, 8'h00);
            tick();
        end
        req(1'b1, 8'hE7, 8'h00);
        tick();
        chk("sat_cnt",  32'(bus.err_cnt_o), 32'd255);
        chk("sat_lerr", 32'(bus.last_err_adr_o), 32'hE7);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_bus_ic.md
# wb_bus_ic

Parametrised single-master Wishbone interconnect that replaces the hand-written strobe decode and DAT/ACK multiplexer in the core. It sits between the bus master (`krake_bus` / `read_fifo`) and up to 16 slave channels. It decodes the upper address field to a slave index and registers the request. It returns ack or error to the master, with an unmapped-address error and a no-ack timeout.

## Interface
- NSLAVES, 12: number of attached slaves, 1..16
- ADR_W, 8: master address width
- DAT_W, 8: data width
- SEL_W, 4: upper address bits used as slave index; requires NSLAVES <= 2^SEL_W
- TIMEOUT_CYC, 255: maximum strobe cycles without ack, 2..255
- clk_i  in  1  system clock; all logic on its rising edge
- rst_i  in  1  reset, synchronous, active-low
- m_stb_i  in  1  request pulse; sampled only while busy_o=0
- m_we_i  in  1  write enable, sampled with m_stb_i
- m_adr_i  in  ADR_W  address, sampled with m_stb_i
- m_dat_i  in  DAT_W  write data, sampled with m_stb_i
- m_dat_o  out  DAT_W  read data, valid while m_ack_o=1
- m_ack_o  out  1  one-cycle completion pulse
- m_err_o  out  1  one-cycle error pulse (unmapped or timeout)
- busy_o  out  1  transaction in progress
- s_stb_o  out  NSLAVES  one-hot slave strobe
- s_we_o  out  1  registered write enable
- s_adr_o  out  ADR_W-SEL_W  registered low address bits
- s_dat_o  out  DAT_W  registered write data
- s_dat_i  in  NSLAVES*DAT_W  slave read data; slave k occupies bits [k*DAT_W +: DAT_W]
- s_ack_i  in  NSLAVES  slave acks
- err_cnt_o  out  8  saturating error count
- last_err_adr_o  out  ADR_W  address of the most recent error

## Operation
- States: IDLE, ACTIVE, RESP, ERR.
- IDLE: if m_stb_i=1, latch we/adr/dat. idx = m_adr_i[ADR_W-1 -: SEL_W].
  - idx < NSLAVES: go to ACTIVE.
  - Otherwise: go to ERR. This is an unmapped address; no slave is strobed.
- ACTIVE: s_stb_o[idx]=1, all other strobe bits 0. s_we_o, s_adr_o and s_dat_o hold the latched values.
  - s_ack_i[idx]=1: capture s_dat_i slice idx and go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP: m_ack_o=1 for one cycle. m_dat_o = captured data on reads. On writes, m_dat_o is the value returned by the addressed slave. Next state is IDLE.
- ERR: m_err_o=1 for one cycle. Increment err_cnt_o, saturating at 255. Load last_err_adr_o. Next state is IDLE.
- busy_o=1 in ACTIVE, RESP and ERR. m_stb_i arriving while busy is dropped with no response.
- m_dat_o holds its last value outside RESP.
- Reset values: every output 0, state IDLE, timeout counter 0.

## Timing
- Request sampled at edge N. s_stb_o is high from cycle N+1.
- Ack sampled high at edge N+1+k (k>=0). s_stb_o drops in the following cycle, and m_ack_o is high in that same cycle.
- Best-case turnaround: slave acks in the first strobe cycle, giving m_ack_o at cycle N+2. The next request can be accepted at the edge ending the RESP cycle.
- Unmapped address: m_err_o high in cycle N+1; s_stb_o never rises.
- Timeout: counter clears on entry to ACTIVE and increments each ACTIVE cycle without ack. s_stb_o is high for exactly TIMEOUT_CYC cycles; the path then goes to ERR, with m_err_o in the next cycle.
- Ack on the final allowed cycle wins over timeout.
- rst_i low at any edge forces IDLE and zero outputs on that edge, aborting any transaction with no ack or err.
- A slave holding ack high after completion has no effect once the state has left ACTIVE.

## Configuration
- WB_IC_TIMEOUT_EN defined: timeout counter and timeout error path are present, as described above.
- WB_IC_TIMEOUT_EN undefined:
  - The counter is removed, and ACTIVE waits indefinitely for ack.
  - Only unmapped addresses raise m_err_o.
  - TIMEOUT_CYC is ignored.

## Test plan
- Read, defaults: m_adr_i=8'h35, slave 3 acks 2 cycles after strobe with 8'hA5. Expect s_stb_o=12'h008, s_adr_o=4'h5, and m_ack_o one cycle with m_dat_o=8'hA5.
- Write: m_we_i=1, m_adr_i=8'hB2, m_dat_i=8'h3C. Expect s_stb_o bit 11 high, s_we_o=1, s_dat_o=8'h3C, and m_ack_o after ack.
- Unmapped: m_adr_i=8'hF0 with NSLAVES=12. Expect no s_stb_o, m_err_o at N+1, err_cnt_o=1, last_err_adr_o=8'hF0.
- Timeout, macro on: TIMEOUT_CYC=4, slave never acks. Expect s_stb_o high exactly 4 cycles, then m_err_o, err_cnt_o incremented. Ack on the 4th cycle instead gives m_ack_o and no error.
- Busy drop and wrong ack: second m_stb_i during ACTIVE produces no response. s_ack_i from a non-selected slave does not complete the transaction.
- Reset mid-transaction: rst_i=0 during ACTIVE. Expect all outputs 0 next cycle, no m_ack_o, and a clean next transaction after release.
